uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 20 ++
 rtl/uart_tx.sv | 118 +++++++++++
 tb/tb_uart_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state type and line-level bit constants shared by the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the enum.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: counts CLKS_PER_BIT cycles while enabled; bit_tick marks the last cycle of a bit,
// pre_tick the cycle before it so the parent can register outputs that land on that last cycle.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bit_tick,
  output logic pre_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE = W'(CLKS_PER_BIT - 2);
  logic [W-1:0] cnt;
  assign bit_tick = cnt == LAST;
  assign pre_tick = cnt == PRE;
  always_ff @(posedge clk)
    cnt <= (!reset || !en || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter with registered tx/tx_n, busy and done pulse.
// Defining UART_TX_PARITY_EN inserts an even parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 tx_n,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  state_t state;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] sh;
  logic bit_tick;
  logic pre_tick;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .en(busy),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );
  // tx_n is written alongside tx in every branch so it stays a registered complement
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tx <= IDLE_LINE;
      tx_n <= ~IDLE_LINE;
      busy <= 1'b0;
      done <= 1'b0;
      in_ready <= 1'b0;
      idx <= '0;
      sh <= '0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state <= START;
            sh <= in_data;
            tx <= START_BIT;
            tx_n <= ~START_BIT;
            busy <= 1'b1;
            in_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par <= ^in_data;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= DATA;
            tx <= sh[0];
            tx_n <= ~sh[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx <= par;
              tx_n <= ~par;
`else
              state <= STOP;
              tx <= STOP_BIT;
              tx_n <= ~STOP_BIT;
`endif
            end else begin
              idx <= idx + 1'b1;
              sh <= sh >> 1;
              tx <= sh[1];
              tx_n <= ~sh[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            tx <= STOP_BIT;
            tx_n <= ~STOP_BIT;
          end
        end
`endif
        STOP: begin
          done <= pre_tick;
          if (bit_tick) begin
            state <= IDLE;
            busy <= 1'b0;
            in_ready <= 1'b1;
            tx <= IDLE_LINE;
            tx_n <= ~IDLE_LINE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; stimulus queues hand-computed serial frames,
// a negedge monitor checks every cycle of each frame plus the idle line and tx_n.
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, tx, tx_n, busy, done;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx(tx),
    .tx_n(tx_n),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] s;
    int len;
    bit abort;
    logic [7:0] d;
  } item_t;

  item_t sb[$];
  item_t cur;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mc = 0;
  int t_acc = 0;
  bit chk_en = 1'b0;
  logic prev_tx = 1'b1;

  always @(posedge clk) cyc++;

  // Serial frames written in transmission order, left-aligned: bit k of the frame is s[10-k].
  function automatic logic [10:0] exp_seq(logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    case (d)
      8'hA5: return 11'b01010010101;
      8'h01: return 11'b01000000011;
      8'h3C: return 11'b00011110001;
      8'hC3: return 11'b01100001101;
      8'h5A: return 11'b00101101001;
      default: return 11'b0;
    endcase
`else
    case (d)
      8'hA5: return {10'b0101001011, 1'b0};
      8'h01: return {10'b0100000001, 1'b0};
      8'h3C: return {10'b0001111001, 1'b0};
      8'hC3: return {10'b0110000111, 1'b0};
      8'h5A: return {10'b0010110101, 1'b0};
      default: return 11'b0;
    endcase
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] e);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_n^tx", {31'b0, tx_n ^ tx}, 32'd1);
      if (mc == 0 && prev_tx && !tx) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected frame: got start bit at cycle %0d expected none", cyc);
        end else begin
          cur = sb.pop_front();
          mc = 1;
        end
      end
      if (mc > 0) begin
        if (mc <= cur.len) begin
          chk($sformatf("tx %02h c%0d", cur.d, mc), {31'b0, tx}, {31'b0, cur.s[10 - (mc - 1) / CPB]});
          chk($sformatf("busy %02h c%0d", cur.d, mc), {31'b0, busy}, 32'd1);
          chk($sformatf("done %02h c%0d", cur.d, mc), {31'b0, done}, {31'b0, (mc == FLEN && !cur.abort)});
          mc++;
        end else begin
          chk($sformatf("post tx %02h", cur.d), {31'b0, tx}, 32'd1);
          chk($sformatf("post busy %02h", cur.d), {31'b0, busy}, 32'd0);
          chk($sformatf("post done %02h", cur.d), {31'b0, done}, 32'd0);
          if (!cur.abort) chk($sformatf("post in_ready %02h", cur.d), {31'b0, in_ready}, 32'd1);
          mc = 0;
        end
      end else begin
        chk("idle busy/done", {30'b0, busy, done}, 32'd0);
      end
      prev_tx = tx;
    end
  end

  task automatic send(logic [7:0] d, bit ab, bit hold);
    int w = 0;
    item_t it;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send %02h: got in_ready 0 for %0d cycles expected 1", d, w);
      in_valid = 1'b0;
      return;
    end
    it.s = exp_seq(d);
    it.len = ab ? 17 : FLEN;
    it.abort = ab;
    it.d = d;
    sb.push_back(it);
    t_acc = cyc;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    repeat (2) @(negedge clk);
    while ((mc != 0 || busy) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (mc != 0 || busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: got busy %0b after %0d cycles expected 0", busy, w);
    end
  endtask

  initial begin
    int t0;
    in_valid = 1'b1;
    in_data = 8'h01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset tx", {31'b0, tx}, 32'd1);
    chk("reset tx_n", {31'b0, tx_n}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("first edge in_ready", {31'b0, in_ready}, 32'd1);
    chk("first edge not accepted", {31'b0, busy}, 32'd0);
    in_valid = 1'b0;
    send(8'h01, 1'b0, 1'b0);
    wait_idle();

    send(8'hA5, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(negedge clk);
    chk("in_ready mid-frame", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();

    send(8'h3C, 1'b0, 1'b1);
    t0 = t_acc;
    send(8'hC3, 1'b0, 1'b0);
    chk("b2b accept spacing", t_acc - t0, FLEN + 1);
    wait_idle();

    send(8'h5A, 1'b1, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    send(8'hA5, 1'b0, 1'b0);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("scoreboard empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global timeout: got no finish by cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
